// File: rtl/suit_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : suit_classifier
//  Description : Picks the best-matching card suit (argmin of four XOR
//                mismatch scores), rejects weak or ambiguous matches, and
//                votes over consecutive frames to publish a stable suit.
//  Ports       : clk, rst                 - clock, synchronous active-high reset
//                *_score_i                - per-suit mismatch counts
//                score_valid_i[3:0]       - one-cycle done strobes, bit i = suit i
//                busy_o                   - set being compared; strobes ignored
//                suit_out_o / suit_valid_o    - per-frame result and its pulse
//                stable_suit_o / stable_valid_o - voted result and its level
//                timeout_err_o            - partial set discarded (pulse)
//  Encoding    : 0 club, 1 diamond, 2 heart, 3 spade, 4 NONE
//  Revision    : 1.0 - initial release
// ============================================================================
module suit_classifier #(
  parameter int SCORE_W        = 10,
  parameter int REJECT_THRESH  = 300,
  parameter int MIN_MARGIN     = 40,
  parameter int CONFIRM_FRAMES = 3,
  parameter int TIMEOUT_CYCLES = 1237500
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] club_score_i,
  input  logic [SCORE_W-1:0] diamond_score_i,
  input  logic [SCORE_W-1:0] heart_score_i,
  input  logic [SCORE_W-1:0] spade_score_i,
  input  logic [3:0]         score_valid_i,
  output logic               busy_o,
  output logic [2:0]         suit_out_o,
  output logic               suit_valid_o,
  output logic [2:0]         stable_suit_o,
  output logic               stable_valid_o,
  output logic               timeout_err_o
);

  localparam int c_TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int c_CNT_W = $clog2(CONFIRM_FRAMES + 1);

  localparam logic [SCORE_W-1:0] c_REJECT  = SCORE_W'(REJECT_THRESH);
  localparam logic [SCORE_W-1:0] c_MARGIN  = SCORE_W'(MIN_MARGIN);
  localparam logic [c_TMR_W-1:0] c_TIMEOUT = c_TMR_W'(TIMEOUT_CYCLES);
  localparam logic [c_TMR_W-1:0] c_TMR_ONE = c_TMR_W'(1);
  localparam logic [c_CNT_W-1:0] c_CONFIRM = c_CNT_W'(CONFIRM_FRAMES);
  localparam logic [c_CNT_W-1:0] c_RUN_ONE = c_CNT_W'(1);
  localparam logic [2:0]         c_NONE    = 3'd4;

  localparam logic [1:0] c_S_COLLECT = 2'd0;
  localparam logic [1:0] c_S_COMPARE = 2'd1;
  localparam logic [1:0] c_S_DECIDE  = 2'd2;
  localparam logic [1:0] c_S_OUTPUT  = 2'd3;

  // Registered state and next-state values
  logic [1:0]                 state_q, state_d;
  logic [3:0]                 got_q, got_d;
  logic [c_TMR_W-1:0]         timer_q, timer_d;
  logic [3:0][SCORE_W-1:0]    score_q, score_d;
  logic [1:0]                 idx_q, idx_d;
  logic [SCORE_W-1:0]         best_q, best_d;
  logic [SCORE_W-1:0]         second_q, second_d;
  logic [1:0]                 best_idx_q, best_idx_d;
  logic [2:0]                 suit_out_q, suit_out_d;
  logic                       suit_valid_q, suit_valid_d;
  logic [2:0]                 stable_suit_q, stable_suit_d;
  logic                       stable_valid_q, stable_valid_d;
  logic                       timeout_err_q, timeout_err_d;
  logic [2:0]                 last_result_q, last_result_d;
  logic [c_CNT_W-1:0]         run_cnt_q, run_cnt_d;

  // Combinational helpers
  logic [3:0][SCORE_W-1:0]    w_in;
  logic [3:0]                 w_got_next;
  logic [c_TMR_W-1:0]         w_timer_next;
  logic [SCORE_W-1:0]         w_cur;
  logic [SCORE_W-1:0]         w_margin;
  logic [2:0]                 w_result;

  assign w_in       = {spade_score_i, heart_score_i, diamond_score_i, club_score_i};
  assign w_got_next = got_q | score_valid_i;
  // The first strobe of a set counts as elapsed cycle 1 at the next edge.
  assign w_timer_next = (got_q == 4'h0) ? c_TMR_ONE : timer_q + 1'b1;
  assign w_cur      = score_q[idx_q];
  // second_q >= best_q always holds after the scan, so this never wraps.
  assign w_margin   = second_q - best_q;
  assign w_result   = ((best_q > c_REJECT) || (w_margin < c_MARGIN)) ? c_NONE
                                                                     : {1'b0, best_idx_q};

  always_comb begin
    state_d        = state_q;
    got_d          = got_q;
    timer_d        = timer_q;
    score_d        = score_q;
    idx_d          = idx_q;
    best_d         = best_q;
    second_d       = second_q;
    best_idx_d     = best_idx_q;
    suit_out_d     = suit_out_q;
    suit_valid_d   = 1'b0;
    stable_suit_d  = stable_suit_q;
    stable_valid_d = stable_valid_q;
    timeout_err_d  = 1'b0;
    last_result_d  = last_result_q;
    run_cnt_d      = run_cnt_q;

    case (state_q)
      c_S_COLLECT: begin
        for (int i = 0; i < 4; i++) begin
          if (score_valid_i[i]) begin
            score_d[i] = w_in[i];
          end
        end
        got_d = w_got_next;
        if (w_got_next != 4'h0) begin
          timer_d = w_timer_next;
        end
        if (w_got_next == 4'hF) begin
          state_d    = c_S_COMPARE;
          timer_d    = '0;
          idx_d      = 2'd0;
          best_d     = '1;
          second_d   = '1;
          best_idx_d = 2'd0;
        end else if ((w_got_next != 4'h0) && (w_timer_next == c_TIMEOUT)) begin
          got_d         = 4'h0;
          timer_d       = '0;
          timeout_err_d = 1'b1;
        end
      end

      c_S_COMPARE: begin
        // Strict less-than: equal scores keep the lower index as best and
        // push the tie into second, giving a zero margin.
        if (w_cur < best_q) begin
          second_d   = best_q;
          best_d     = w_cur;
          best_idx_d = idx_q;
        end else if (w_cur < second_q) begin
          second_d = w_cur;
        end
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = c_S_DECIDE;
        end
      end

      c_S_DECIDE: begin
        // Result and vote are registered here so they appear in OUTPUT.
        suit_out_d   = w_result;
        suit_valid_d = 1'b1;
        if (w_result == last_result_q) begin
          if (run_cnt_q != c_CONFIRM) begin
            run_cnt_d = run_cnt_q + 1'b1;
          end
        end else begin
          last_result_d = w_result;
          run_cnt_d     = c_RUN_ONE;
        end
        if (run_cnt_d == c_CONFIRM) begin
          stable_suit_d  = w_result;
          stable_valid_d = 1'b1;
        end
        state_d = c_S_OUTPUT;
      end

      c_S_OUTPUT: begin
        got_d   = 4'h0;
        state_d = c_S_COLLECT;
      end

      default: begin
        state_d = c_S_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= c_S_COLLECT;
      got_q          <= 4'h0;
      timer_q        <= '0;
      score_q        <= '0;
      idx_q          <= 2'd0;
      best_q         <= '1;
      second_q       <= '1;
      best_idx_q     <= 2'd0;
      suit_out_q     <= 3'd0;
      suit_valid_q   <= 1'b0;
      stable_suit_q  <= 3'd0;
      stable_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      last_result_q  <= c_NONE;
      run_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      got_q          <= got_d;
      timer_q        <= timer_d;
      score_q        <= score_d;
      idx_q          <= idx_d;
      best_q         <= best_d;
      second_q       <= second_d;
      best_idx_q     <= best_idx_d;
      suit_out_q     <= suit_out_d;
      suit_valid_q   <= suit_valid_d;
      stable_suit_q  <= stable_suit_d;
      stable_valid_q <= stable_valid_d;
      timeout_err_q  <= timeout_err_d;
      last_result_q  <= last_result_d;
      run_cnt_q      <= run_cnt_d;
    end
  end

  assign busy_o         = (state_q != c_S_COLLECT);
  assign suit_out_o     = suit_out_q;
  assign suit_valid_o   = suit_valid_q;
  assign stable_suit_o  = stable_suit_q;
  assign stable_valid_o = stable_valid_q;
  assign timeout_err_o  = timeout_err_q;

endmodule
`default_nettype wire
